// File: rtl/xphm_rd_seq_pkg.sv
// Shared definitions for the XPHM read-side scheduler.
package xphm_rd_seq_pkg;

   localparam int unsigned XphmDepth        = 64;
   localparam int unsigned XphmNumPipe      = 2;
   localparam int unsigned XphmRdseqCredits = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } rd_seq_state_e;

endpackage

// File: rtl/xphm_rd_credit.sv
// Saturating up/down credit counter mirroring free slots in the downstream head FIFO.
module xphm_rd_credit
   import xphm_rd_seq_pkg::*;
#(
   parameter int unsigned Credits = XphmRdseqCredits
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic issue_i,
   input  logic ret_i,
   output logic can_issue_o
);

   localparam int unsigned    CrW   = $clog2(Credits + 1);
   localparam logic [CrW-1:0] CrMax = CrW'(Credits);

   logic [CrW-1:0] credit_q, credit_d;

   always_comb begin
      credit_d = credit_q;
      if (issue_i && !ret_i) begin
         credit_d = credit_q - 1'b1;
      end else if (ret_i && !issue_i && (credit_q != CrMax)) begin
         credit_d = credit_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credit_q <= CrMax;
      end else begin
         credit_q <= credit_d;
      end
   end

   // Decision uses the registered count only: no path from ret_i to issue.
   assign can_issue_o = (credit_q != '0);

   // A return while already full means the downstream side popped more than it received.
   cr_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(ret_i && !issue_i && (credit_q == CrMax)));

endmodule

// File: rtl/xphm_rd_seq.sv
// Issues n_heads x n_rounds XPHM reads from base_addr, gated by downstream FIFO credit.
module xphm_rd_seq
   import xphm_rd_seq_pkg::*;
#(
   parameter int unsigned Depth     = XphmDepth,
   parameter int unsigned AddrWidth = $clog2(Depth),
   parameter int unsigned CntWidth  = 16,
   parameter int unsigned Credits   = XphmRdseqCredits,
   parameter int unsigned Lat       = XphmNumPipe + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_pulse_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [CntWidth-1:0]  n_heads_i,
   input  logic [CntWidth-1:0]  n_rounds_i,
   output logic                 busy_o,
   output logic                 done_pulse_o,
   output logic                 rd_en_o,
   output logic                 rd_last_o,
   output logic [AddrWidth-1:0] rd_addr_o,
   input  logic                 dout_last_i,
   input  logic                 cr_ret_i
);

   rd_seq_state_e        state_q;
   logic [AddrWidth-1:0] base_q, addr_q, rd_addr_q;
   logic [CntWidth-1:0]  head_last_q, round_last_q, head_q, round_q;
   logic                 busy_q, done_pulse_q, rd_en_q, rd_last_q;

   logic                 idle_start, empty_job, can_issue, issue, head_wrap, job_last;
   logic [AddrWidth-1:0] cur_base, cur_addr, next_addr;
   logic [CntWidth-1:0]  cur_head, cur_round, cur_head_last, cur_round_last;

   xphm_rd_credit #(
      .Credits(Credits)
   ) u_credit (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .issue_i    (issue),
      .ret_i      (cr_ret_i),
      .can_issue_o(can_issue)
   );

   // An accepted start issues its first read in the same cycle, so the job
   // view is taken from the inputs while idle and from the latches afterwards.
   always_comb begin
      idle_start     = (state_q == StIdle) && start_pulse_i;
      empty_job      = (n_heads_i == '0) || (n_rounds_i == '0);
      cur_base       = idle_start ? base_addr_i : base_q;
      cur_addr       = idle_start ? base_addr_i : addr_q;
      cur_head       = idle_start ? '0 : head_q;
      cur_round      = idle_start ? '0 : round_q;
      cur_head_last  = idle_start ? n_heads_i - CntWidth'(1) : head_last_q;
      cur_round_last = idle_start ? n_rounds_i - CntWidth'(1) : round_last_q;
      issue          = can_issue && ((idle_start && !empty_job) || (state_q == StRun));
      head_wrap      = (cur_head == cur_head_last);
      job_last       = head_wrap && (cur_round == cur_round_last);
      next_addr      = (cur_addr == AddrWidth'(Depth - 1)) ? '0 : cur_addr + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         base_q       <= '0;
         addr_q       <= '0;
         rd_addr_q    <= '0;
         head_last_q  <= '0;
         round_last_q <= '0;
         head_q       <= '0;
         round_q      <= '0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_last_q    <= 1'b0;
      end else begin
         rd_en_q      <= issue;
         rd_last_q    <= issue && job_last;
         done_pulse_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_pulse_i) begin
                  base_q       <= base_addr_i;
                  addr_q       <= base_addr_i;
                  head_last_q  <= n_heads_i - CntWidth'(1);
                  round_last_q <= n_rounds_i - CntWidth'(1);
                  head_q       <= '0;
                  round_q      <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= empty_job ? StDone : StRun;
               end
            end
            StDrain: begin
               if (dout_last_i) begin
                  done_pulse_q <= 1'b1;
                  state_q      <= StDone;
               end
            end
            StDone: begin
               // Empty jobs arrive with done low and spend one extra cycle here.
               if (done_pulse_q) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  done_pulse_q <= 1'b1;
               end
            end
            default: ;
         endcase
         if (issue) begin
            rd_addr_q <= cur_addr;
            if (head_wrap) begin
               addr_q  <= cur_base;
               head_q  <= '0;
               round_q <= cur_round + CntWidth'(1);
            end else begin
               addr_q <= next_addr;
               head_q <= cur_head + CntWidth'(1);
            end
            if (job_last) begin
               state_q <= StDrain;
            end
         end
      end
   end

   assign busy_o       = busy_q;
   assign done_pulse_o = done_pulse_q;
   assign rd_en_o      = rd_en_q;
   assign rd_last_o    = rd_last_q;
   assign rd_addr_o    = rd_addr_q;

   dout_lat_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rd_last_q |-> ##Lat dout_last_i);

endmodule

// File: tb/tb_xphm_rd_seq.sv
// Scoreboard bench for xphm_rd_seq with an XPHM latency pipe and a downstream FIFO model.
module tb_xphm_rd_seq;

   localparam int unsigned DEP = 16;
   localparam int unsigned AW  = 4;
   localparam int unsigned CW  = 8;
   localparam int unsigned CR  = 4;
   localparam int unsigned LT  = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_pulse;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] n_heads, n_rounds;
   logic          busy, done_pulse, rd_en, rd_last;
   logic [AW-1:0] rd_addr;
   logic          dout_last, dout_vld, cr_ret;

   xphm_rd_seq #(
      .Depth    (DEP),
      .AddrWidth(AW),
      .CntWidth (CW),
      .Credits  (CR),
      .Lat      (LT)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_pulse_i(start_pulse),
      .base_addr_i  (base_addr),
      .n_heads_i    (n_heads),
      .n_rounds_i   (n_rounds),
      .busy_o       (busy),
      .done_pulse_o (done_pulse),
      .rd_en_o      (rd_en),
      .rd_last_o    (rd_last),
      .rd_addr_o    (rd_addr),
      .dout_last_i  (dout_last),
      .cr_ret_i     (cr_ret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          last;
   } rd_t;

   rd_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          job_start = -1;
   int          exp_done = -1;
   int          reads_seen = 0;
   int unsigned pop_pct = 100;

   logic [LT-1:0] vld_pipe, last_pipe;
   int            fifo_cnt, avail;

   always @(posedge clk) cyc <= cyc + 1;

   // XPHM fixed-latency output and downstream head FIFO that returns credits as it pops.
   assign dout_vld  = vld_pipe[LT-1];
   assign dout_last = last_pipe[LT-1];
   always_comb avail = fifo_cnt + int'(dout_vld) - int'(cr_ret);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         fifo_cnt  <= 0;
         cr_ret    <= 1'b0;
      end else begin
         vld_pipe  <= {vld_pipe[LT-2:0], rd_en};
         last_pipe <= {last_pipe[LT-2:0], rd_en & rd_last};
         fifo_cnt  <= avail;
         cr_ret    <= (avail > 0) && ($urandom_range(0, 99) < pop_pct);
      end
   end

   initial begin : monitor
      int  mcredit;
      int  mc_prev;
      bit  prev_ret;
      bit  prev_pending;
      bit  exp_busy;
      rd_t e;
      mcredit      = CR;
      prev_ret     = 1'b0;
      prev_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mcredit      = CR;
            prev_ret     = 1'b0;
            prev_pending = 1'b0;
         end else begin
            mc_prev = mcredit;
            if (prev_pending && mc_prev > 0) begin
               total++;
               if (!rd_en) begin
                  bad++;
                  $display("FAIL stall cyc=%0d rd_en=%0b required 1 (credit %0d)", cyc, rd_en,
                           mc_prev);
               end
            end
            if (rd_en) begin
               reads_seen++;
               total++;
               if (mc_prev == 0) begin
                  bad++;
                  $display("FAIL credit cyc=%0d read issued with credit 0, required none", cyc);
               end
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL extra_read cyc=%0d addr=%0d required no read", cyc, rd_addr);
               end else begin
                  e = exp_q.pop_front();
                  if (rd_addr !== e.addr || rd_last !== e.last) begin
                     bad++;
                     $display("FAIL read cyc=%0d addr=%0d last=%0b required addr=%0d last=%0b",
                              cyc, rd_addr, rd_last, e.addr, e.last);
                  end
                  if (e.last) exp_done = cyc + LT + 1;
               end
            end
            if (done_pulse || cyc == exp_done) begin
               total++;
               if (!(done_pulse && cyc == exp_done)) begin
                  bad++;
                  $display("FAIL done cyc=%0d done_pulse=%0b required done at cyc %0d", cyc,
                           done_pulse, exp_done);
               end
            end
            exp_busy = (job_start >= 0) && (cyc > job_start) && (exp_done < 0 || cyc <= exp_done);
            total++;
            if (busy !== exp_busy) begin
               bad++;
               $display("FAIL busy cyc=%0d busy=%0b required %0b", cyc, busy, exp_busy);
            end
            mcredit      = mc_prev - int'(rd_en) + int'(prev_ret);
            prev_ret     = cr_ret;
            prev_pending = exp_q.size() > 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int base, input int nh, input int nr);
      rd_t e;
      tick();
      start_pulse = 1'b1;
      base_addr   = AW'(base);
      n_heads     = CW'(nh);
      n_rounds    = CW'(nr);
      job_start   = cyc;
      exp_done    = (nh == 0 || nr == 0) ? cyc + 2 : -1;
      for (int r = 0; r < nr; r++) begin
         for (int h = 0; h < nh; h++) begin
            e.addr = AW'((base + h) % DEP);
            e.last = (r == nr - 1) && (h == nh - 1);
            exp_q.push_back(e);
         end
      end
      tick();
      start_pulse = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done_pulse) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL timeout_%s done_pulse never seen, required one", name);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_%s %0d reads outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic check_credit(input string name);
      pop_pct = 100;
      repeat (LT + CR + 4) tick();
      total++;
      if (int'(dut.u_credit.credit_q) != CR) begin
         bad++;
         $display("FAIL %s credit=%0d required %0d", name, dut.u_credit.credit_q, CR);
      end
   endtask

   initial begin : stim
      int rs0;
      rst_n       = 1'b0;
      start_pulse = 1'b0;
      base_addr   = '0;
      n_heads     = '0;
      n_rounds    = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done_pulse, rd_en, rd_last} !== 4'b0 || rd_addr !== '0) begin
         bad++;
         $display("FAIL reset busy=%0b done=%0b rd_en=%0b rd_last=%0b addr=%0d required all 0",
                  busy, done_pulse, rd_en, rd_last, rd_addr);
      end
      rst_n = 1'b1;
      check_credit("reset_credit");

      pop_pct = 100;
      start_job(10, 4, 2);
      wait_done("basic");
      start_job(DEP - 2, 4, 1);
      wait_done("wrap");
      pop_pct = 15;
      start_job(3, 9, 1);
      wait_done("stall");
      check_credit("stall_credit");
      start_job(5, 0, 3);
      wait_done("empty_heads");
      start_job(5, 2, 0);
      wait_done("empty_rounds");

      // Second start while running must not disturb the job in flight.
      pop_pct = 100;
      start_job(1, 5, 2);
      repeat (2) tick();
      start_pulse = 1'b1;
      base_addr   = AW'(7);
      n_heads     = CW'(1);
      n_rounds    = CW'(1);
      tick();
      start_pulse = 1'b0;
      wait_done("restart");

      rs0 = reads_seen;
      start_job(2, 8, 2);
      for (int i = 0; i < 200 && (reads_seen - rs0) < 3; i++) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done_pulse, rd_en, rd_last} !== 4'b0 || rd_addr !== '0) begin
         bad++;
         $display("FAIL mid_reset busy=%0b done=%0b rd_en=%0b rd_last=%0b addr=%0d required 0",
                  busy, done_pulse, rd_en, rd_last, rd_addr);
      end
      exp_q.delete();
      job_start = -1;
      exp_done  = -1;
      tick();
      rst_n = 1'b1;
      check_credit("post_reset_credit");
      start_job(0, 3, 2);
      wait_done("post_reset_job");

      for (int j = 0; j < 8; j++) begin
         pop_pct = $urandom_range(10, 100);
         start_job(int'($urandom_range(0, DEP - 1)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)));
         wait_done("rand");
      end
      check_credit("final_credit");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
